// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL control/status bundle between the sequencer and the board PLL/core.
interface pll_lock_sequencer_if;
    logic       isLocked;
    logic       pllResetN;
    logic       coreReset;
    logic       pllReady;
    logic       pllFault;
    logic [7:0] retryCount;
    logic [7:0] lossCount;
    modport master (
        input  isLocked,
        output pllResetN, coreReset, pllReady, pllFault, retryCount, lossCount
    );
    modport slave (
        output isLocked,
        input  pllResetN, coreReset, pllReady, pllFault, retryCount, lossCount
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL reset, qualifies LOCK, releases core reset, retries then faults.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_WIDTH           = 17
) (
    input logic clk,
    input logic reset,
    pll_lock_sequencer_if.master bus
);
    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
    state_t state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [7:0] retry, retry_n, loss, loss_n;
    logic [SYNC_STAGES-1:0] lock_pipe;
    logic lock_sync;
    assign lock_sync = lock_pipe[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_pipe <= '0;
            state     <= PLL_RST;
            cnt       <= '0;
            retry     <= '0;
            loss      <= '0;
        end else begin
            lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], bus.isLocked};
            state     <= state_n;
            cnt       <= cnt_n;
            retry     <= retry_n;
            loss      <= loss_n;
        end
    end
    always_comb begin
        state_n = state;
        retry_n = retry;
        loss_n  = loss;
        cnt_n   = (state == RUN || state == FAULT) ? cnt : cnt + 1'b1;
        unique case (state)
            PLL_RST:
                if (cnt == CNT_WIDTH'(PLL_RESET_CYCLES - 1)) state_n = WAIT_LOCK;
            WAIT_LOCK:
                if (lock_sync) state_n = STABLE;
                else if (cnt == CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_n = (retry < 8'(MAX_RETRIES)) ? PLL_RST : FAULT;
                    retry_n = (retry < 8'(MAX_RETRIES)) ? retry + 8'd1 : retry;
                end
            STABLE:
                if (!lock_sync) state_n = WAIT_LOCK;
                else if (cnt == CNT_WIDTH'(LOCK_STABLE_CYCLES - 1)) begin
                    state_n = RUN;
                    retry_n = '0;
                end
            RUN:
                if (!lock_sync) begin
                    state_n = PLL_RST;
                    loss_n  = (loss == 8'hff) ? loss : loss + 8'd1;
                end
            FAULT: state_n = FAULT;
            default: state_n = PLL_RST;
        endcase
        // every state change restarts the shared counter
        if (state_n != state) cnt_n = '0;
    end
    assign bus.pllResetN  = !(state == PLL_RST || state == FAULT);
    assign bus.coreReset  = state != RUN;
    assign bus.pllReady   = state == RUN;
    assign bus.pllFault   = state == FAULT;
    assign bus.retryCount = retry;
    assign bus.lossCount  = loss;
endmodule
